// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch path: bu_op codes, CCR flag positions and
// the resolve-unit FSM states. The control-unit decoder imports the same constants.
package branch_pkg;

  localparam logic [2:0] BU_NOP  = 3'b000;
  localparam logic [2:0] BU_JZ   = 3'b001;
  localparam logic [2:0] BU_JN   = 3'b010;
  localparam logic [2:0] BU_JC   = 3'b011;
  localparam logic [2:0] BU_JV   = 3'b100;
  localparam logic [2:0] BU_LOOP = 3'b101;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bru_state_e;

  // Codes above LOOP are reserved and reported as illegal.
  function automatic logic is_reserved_op(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the ID/EX register / CCR (master side) and the branch resolve
// unit (slave side), including the PC-mux, flush and write-back outputs.
interface branch_resolve_unit_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);

  logic              valid_in;
  logic              stall_in;
  logic [2:0]        bu_op;
  logic [3:0]        flags_in;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;
  logic [1:0]        ra_idx;

  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic              flush;
  logic              wb_en;
  logic [1:0]        wb_idx;
  logic [DATA_W-1:0] wb_data;
  logic              bad_op;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output valid_in, stall_in, bu_op, flags_in, ra_val, rb_val, ra_idx,
    input  pc_load, pc_target, flush, wb_en, wb_idx, wb_data, bad_op, taken_cnt
  );

  modport slave (
    input  valid_in, stall_in, bu_op, flags_in, ra_val, rb_val, ra_idx,
    output pc_load, pc_target, flush, wb_en, wb_idx, wb_data, bad_op, taken_cnt
  );

endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Purely combinational branch condition evaluation: selects the CCR flag for
// conditional jumps and computes the LOOP decrement and its taken decision.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        bu_op_i,
  input  logic [3:0]        flags_i,
  input  logic [DATA_W-1:0] ra_val_i,
  output logic              taken_o,
  output logic              is_loop_o,
  output logic              bad_o,
  output logic [DATA_W-1:0] dec_val_o
);

  always_comb begin
    taken_o   = 1'b0;
    is_loop_o = 1'b0;
    bad_o     = is_reserved_op(bu_op_i);
    dec_val_o = ra_val_i - DATA_W'(1);
    case (bu_op_i)
      BU_JZ:   taken_o = flags_i[FLG_Z];
      BU_JN:   taken_o = flags_i[FLG_N];
      BU_JC:   taken_o = flags_i[FLG_C];
      BU_JV:   taken_o = flags_i[FLG_V];
      // A zero counter wraps to all-ones and keeps looping.
      BU_LOOP: begin
        is_loop_o = 1'b1;
        taken_o   = (dec_val_o != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolve unit: captures a branch slot, registers the PC
// redirect / LOOP write-back pulses and runs a fixed-length wrong-path flush.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  bru_state_e        state_q;
  logic [FC_W-1:0]   fcnt_q;
  logic              pc_load_q;
  logic [DATA_W-1:0] pc_target_q;
  logic              wb_en_q;
  logic [1:0]        wb_idx_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              bad_op_q;
  logic [CNT_W-1:0]  taken_cnt_q;
  logic [CNT_W-1:0]  taken_cnt_d;

  logic              capture;
  logic              taken;
  logic              is_loop;
  logic              bad;
  logic [DATA_W-1:0] dec_val;

  branch_cond_eval #(.DATA_W(DATA_W)) u_cond (
    .bu_op_i   (bus.bu_op),
    .flags_i   (bus.flags_in),
    .ra_val_i  (bus.ra_val),
    .taken_o   (taken),
    .is_loop_o (is_loop),
    .bad_o     (bad),
    .dec_val_o (dec_val)
  );

  // Slots arriving during FLUSH are wrong-path and never reach the FSM.
  assign capture     = bus.valid_in && !bus.stall_in && (state_q == IDLE);
  assign taken_cnt_d = (taken_cnt_q == '1) ? taken_cnt_q : taken_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fcnt_q      <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      wb_en_q     <= 1'b0;
      wb_idx_q    <= '0;
      wb_data_q   <= '0;
      bad_op_q    <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      pc_load_q <= 1'b0;
      wb_en_q   <= 1'b0;
      bad_op_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (capture) begin
            bad_op_q <= bad;
            if (is_loop) begin
              wb_en_q   <= 1'b1;
              wb_idx_q  <= bus.ra_idx;
              wb_data_q <= dec_val;
            end
            if (taken) begin
              pc_load_q   <= 1'b1;
              pc_target_q <= bus.rb_val;
              taken_cnt_q <= taken_cnt_d;
              fcnt_q      <= FC_LOAD;
              state_q     <= FLUSH;
            end
          end
        end
        // The flush length is fixed; a pipeline stall does not stretch it.
        FLUSH: begin
          if (fcnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            fcnt_q <= fcnt_q - FC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc_load   = pc_load_q;
  assign bus.pc_target = pc_target_q;
  assign bus.flush     = (state_q == FLUSH);
  assign bus.wb_en     = wb_en_q;
  assign bus.wb_idx    = wb_idx_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.bad_op    = bad_op_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed slots push hand-computed
// responses; a negedge monitor pops and compares whenever a pulse appears.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  typedef struct {
    logic       load;
    logic [7:0] target;
    logic       wb;
    logic [1:0] idx;
    logic [7:0] wdata;
    logic       bad;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];
  exp_t monExp;

  branch_resolve_unit_if #(.DATA_W(8), .CNT_W(16)) bus ();

  branch_resolve_unit #(.DATA_W(8), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; presents one slot for the next rising edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] flags,
                               input logic [7:0] ra, input logic [7:0] rb,
                               input logic [1:0] idx, input logic stall,
                               input logic expLoad, input logic [7:0] expTarget,
                               input logic expWb, input logic [7:0] expWdata,
                               input logic expBad);
    exp_t e;
    bus.valid_in = 1'b1;
    bus.stall_in = stall;
    bus.bu_op    = op;
    bus.flags_in = flags;
    bus.ra_val   = ra;
    bus.rb_val   = rb;
    bus.ra_idx   = idx;
    if (expLoad || expWb || expBad) begin
      e.load   = expLoad;
      e.target = expTarget;
      e.wb     = expWb;
      e.idx    = idx;
      e.wdata  = expWdata;
      e.bad    = expBad;
      expQ.push_back(e);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.stall_in = 1'b0;
  endtask

  task automatic waitFlush(input int expected, input string name);
    int n = 0;
    while (bus.flush && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, n, expected);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pc_load"}, bus.pc_load, 0);
    checkOutput({tag, "_flush"}, bus.flush, 0);
    checkOutput({tag, "_wb_en"}, bus.wb_en, 0);
    checkOutput({tag, "_bad_op"}, bus.bad_op, 0);
    checkOutput({tag, "_pc_target"}, bus.pc_target, 0);
    checkOutput({tag, "_wb_data"}, bus.wb_data, 0);
    checkOutput({tag, "_wb_idx"}, bus.wb_idx, 0);
    checkOutput({tag, "_taken_cnt"}, bus.taken_cnt, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.pc_load || bus.wb_en || bus.bad_op)) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse actual=load%0b/wb%0b/bad%0b expected=none",
                 bus.pc_load, bus.wb_en, bus.bad_op);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("mon_pc_load", bus.pc_load, monExp.load);
        if (monExp.load) checkOutput("mon_pc_target", bus.pc_target, monExp.target);
        checkOutput("mon_wb_en", bus.wb_en, monExp.wb);
        if (monExp.wb) begin
          checkOutput("mon_wb_idx", bus.wb_idx, monExp.idx);
          checkOutput("mon_wb_data", bus.wb_data, monExp.wdata);
        end
        checkOutput("mon_bad_op", bus.bad_op, monExp.bad);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.stall_in = 1'b0;
    bus.bu_op    = BU_NOP;
    bus.flags_in = 4'b0000;
    bus.ra_val   = 8'h00;
    bus.rb_val   = 8'h00;
    bus.ra_idx   = 2'd0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Taken JZ: redirect to 0x3C, two flush cycles, one taken branch counted.
    applyStimulus(BU_JZ, 4'b0001, 8'h00, 8'h3C, 2'd0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    checkOutput("s1_flush_rise", bus.flush, 1);
    checkOutput("s1_taken_cnt", bus.taken_cnt, 1);
    waitFlush(2, "s1_flush_len");

    // Not-taken JC immediately followed by taken JN.
    applyStimulus(BU_JC, 4'b0000, 8'h00, 8'h99, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("s2_jc_no_load", bus.pc_load, 0);
    applyStimulus(BU_JN, 4'b0010, 8'h00, 8'h55, 2'd0, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    checkOutput("s2_taken_cnt", bus.taken_cnt, 2);
    waitFlush(2, "s2_flush_len");

    // LOOP 1 -> 0 falls through; LOOP 0 -> FF is taken.
    applyStimulus(BU_LOOP, 4'b0000, 8'h01, 8'h20, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    checkOutput("s3_no_flush", bus.flush, 0);
    applyStimulus(BU_LOOP, 4'b0000, 8'h00, 8'h40, 2'd1, 1'b0, 1'b1, 8'h40, 1'b1, 8'hFF, 1'b0);
    checkOutput("s3_taken_cnt", bus.taken_cnt, 3);
    waitFlush(2, "s3_flush_len");

    // Taken JV then two LOOPs inside the flush window are discarded.
    applyStimulus(BU_JV, 4'b1000, 8'h00, 8'h77, 2'd0, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    applyStimulus(BU_LOOP, 4'b0000, 8'h05, 8'h10, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(BU_LOOP, 4'b0000, 8'h09, 8'h10, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("s4_taken_cnt", bus.taken_cnt, 4);
    checkOutput("s4_flush_done", bus.flush, 0);
    checkOutput("s4_wb_data_held", bus.wb_data, 8'hFF);

    // Reserved opcode, then a stalled taken JZ that must not be captured.
    applyStimulus(3'b111, 4'b1111, 8'h00, 8'h12, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("s5_bad_no_flush", bus.flush, 0);
    applyStimulus(BU_JZ, 4'b0001, 8'h00, 8'hAA, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("s5_stall_cnt", bus.taken_cnt, 4);
    checkOutput("s5_stall_no_flush", bus.flush, 0);
    checkOutput("s5_target_held", bus.pc_target, 8'h77);

    // Reset one cycle into a flush aborts it; a fresh JZ behaves as after power-up.
    applyStimulus(BU_JZ, 4'b0001, 8'h00, 8'h3C, 2'd0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkAllZero("s6_abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(BU_JZ, 4'b0001, 8'h00, 8'h3C, 2'd0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    checkOutput("s6_taken_cnt", bus.taken_cnt, 1);
    waitFlush(2, "s6_flush_len");

    repeat (2) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
